gc_rx_decoder: RTL and testbench
================================

Name: gc_rx_decoder

Overview:
- Receive stage directly downstream of the GameCube poll generator. Once the command has been transmitted and the poll generator releases the line, this block captures the controller's reply on the open-drain GC data line.
- Decodes the reply: synchronise the line, detect falling edges, then mid-bit sample each 4 us cell. Checks the stop bit and publishes the frame plus decoded stick/button fields.
- Pulses ready back to the poll generator, which re-arms it.

Parameters:
- SAMPLE_CLKS, 120, clocks after a falling edge at which the bit is sampled (2 us at 60 MHz).
- BIT_MAX_CLKS, 480, maximum clocks the line may stay low in one cell before a stuck-low error is declared.
- TIMEOUT_CLKS, 6000, maximum clocks to wait for the next falling edge (100 us) before a timeout error.

Ports:
- clk  in  1  60 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- gc_data_in  in  1  raw GC data line, asynchronous to clk
- gc_enable  in  1  from poll generator; 1 = line released / listening, 0 = poll generator driving
- connection_type  in  3  0 = probe (24-bit reply), 1 = origin (80-bit reply), other = poll (64-bit reply)
- ready  out  1  one-cycle pulse when a frame completes, valid or error; drives poll generator ready
- rx_valid  out  1  one-cycle pulse, frame good; coincident with ready
- rx_error  out  1  one-cycle pulse, frame bad; coincident with ready
- rx_len  out  7  number of data bits in the last completed frame
- rx_data  out  80  last frame, right-aligned, first received bit at rx_data[rx_len-1]
- buttons  out  16  poll reply bits 63:48
- stick_x, stick_y, cstick_x, cstick_y, trig_l, trig_r  out  8 each  poll reply bytes 47:40 through 7:0, in that order

Behaviour:
- Reset: all outputs 0; state IDLE; synchroniser flops set to 1 (idle-high line).
- Input path:
  - gc_data_in passes through a 2-flop synchroniser, followed by a registered copy for edge detection.
  - All edge and level references below use the synchronised signal; the edge is seen 3 clocks after the pin.
- IDLE:
  - Arm on a gc_enable 0->1 transition, i.e. end of command transmission. A level-high gc_enable alone does not arm.
  - At arm time latch the expected length N: 24, 80 or 64 from connection_type. Clear the shift register and the bit counter (7 bits). Go to WAIT_EDGE.
- WAIT_EDGE:
  - A wait counter runs from 0.
  - Falling edge: clear the cell counter, go to SAMPLE.
  - Counter reaches TIMEOUT_CLKS-1 with no edge: error completion.
- SAMPLE:
  - Cell counter increments.
  - At count SAMPLE_CLKS-1, shift in the line level MSB-first: shreg <= {shreg[78:0], line}. High = 1, low = 0.
  - Increment the bit counter, go to WAIT_HIGH.
- WAIT_HIGH:
  - Wait for line = 1. If the cell counter reaches BIT_MAX_CLKS-1 while still low: error completion.
  - On line = 1: if bit counter == N go to STOP, else go to WAIT_EDGE.
- STOP:
  - Requires one more falling edge within TIMEOUT_CLKS; timeout gives an error completion.
  - The line must then return high within BIT_MAX_CLKS of that edge, otherwise error completion.
  - Line returns high in time: valid completion.
- Valid completion, in one clock:
  - rx_data <= shreg with bits above N zeroed; rx_len <= N.
  - If N == 64, update buttons and the stick/trigger fields; otherwise those outputs hold.
  - Pulse ready and rx_valid; return to IDLE.
- Error completion:
  - rx_data, rx_len and the decoded fields hold their previous values.
  - Pulse ready and rx_error; return to IDLE.
- gc_enable falling 0 while not in IDLE (poll generator started transmitting):
  - Abort immediately to IDLE with no ready, rx_valid or rx_error pulse.
  - Abort has priority over any completion in the same cycle.
- connection_type changes after arm are ignored until the next arm.
- rst_n low at any time clears everything asynchronously, including mid-frame. No pulse is emitted on release.
- Latency: ready is asserted on the clock after the stop-bit rising edge is seen on the synchronised line.

Decomposition:
- Shared package gc_pkg:
  - GC_LEN_PROBE = 24, GC_LEN_ORIGIN = 80, GC_LEN_POLL = 64.
  - connection_type encodings CT_PROBE = 0, CT_ORIGIN = 1, CT_POLL = 2.
  - Receiver state enum {IDLE, WAIT_EDGE, SAMPLE, WAIT_HIGH, STOP}.
  - Default timing constants.
- One sub-module, gc_line_sync: 2-flop synchroniser plus falling/rising edge strobes, reset-to-1.

Test Plan:
- Poll frame: connection_type = 2, gc_enable 0->1, model sends 64 cells (1 = 1 us low/3 us high, 0 = 3 us low/1 us high) carrying 0x0080_8080_8080_2020, then stop bit -> one ready + rx_valid pulse, rx_len = 64, buttons = 0x0080, stick_x = 0x80, trig_r = 0x20.
- Probe reply: connection_type = 0, 24 bits 0x090000 + stop -> rx_valid, rx_len = 24, rx_data = 0x090000; buttons and stick fields unchanged.
- Timeout: arm with connection_type = 2, controller absent -> rx_error + ready pulse exactly TIMEOUT_CLKS clocks after arm, within ±3 synchroniser clocks; rx_data unchanged.
- Stuck low: line held low 10 us during bit 5 -> rx_error at BIT_MAX_CLKS after that falling edge; no rx_valid.
- Abort: gc_enable drops to 0 after 30 bits received -> state IDLE, no ready/rx_valid/rx_error pulse; the next armed good frame decodes correctly.
- Reset mid-frame: rst_n low for 2 clocks during bit 40 -> all outputs 0 immediately; no pulse after release; the next armed frame decodes correctly.

Source files
------------

// File: rtl/gc_pkg.sv
// Shared constants, encodings and helpers for the GameCube reply receiver.
package gc_pkg;

  // Reply lengths in data bits, excluding the stop bit
  localparam int GC_LEN_PROBE  = 24;
  localparam int GC_LEN_ORIGIN = 80;
  localparam int GC_LEN_POLL   = 64;
  localparam int GC_MAX_BITS   = 80;

  // connection_type encodings; anything else is treated as a poll
  localparam logic [2:0] CT_PROBE  = 3'd0;
  localparam logic [2:0] CT_ORIGIN = 3'd1;
  localparam logic [2:0] CT_POLL   = 3'd2;

  // Default timing at 60 MHz: 2 us sample point, 8 us stuck-low, 100 us timeout
  localparam int GC_SAMPLE_CLKS  = 120;
  localparam int GC_BIT_MAX_CLKS = 480;
  localparam int GC_TIMEOUT_CLKS = 6000;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_EDGE,
    SAMPLE,
    WAIT_HIGH,
    STOP
  } gcRxState_t;

  // Expected reply length for a given connection type
  function automatic logic [6:0] gcReplyLen(input logic [2:0] connType);
    logic [6:0] len;
    case (connType)
      CT_PROBE:  len = 7'(GC_LEN_PROBE);
      CT_ORIGIN: len = 7'(GC_LEN_ORIGIN);
      default:   len = 7'(GC_LEN_POLL);
    endcase
    return len;
  endfunction

  // Mask keeping only the low 'len' bits of a full-width frame
  function automatic logic [GC_MAX_BITS-1:0] gcLenMask(input logic [6:0] len);
    logic [GC_MAX_BITS-1:0] mask;
    mask = '0;
    for (int i = 0; i < GC_MAX_BITS; i++) begin
      mask[i] = (i < int'(len));
    end
    return mask;
  endfunction

endpackage

// File: rtl/gc_line_sync.sv
// Two-flop synchroniser for the open-drain GC data line plus edge strobes.
// All flops reset to 1 because the idle line is pulled high.
module gc_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_line,
  output logic o_fall,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Bring the pin into the clock domain and keep one delayed copy for edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_line = r_sync;
  assign o_fall = r_prev & ~r_sync;
  assign o_rise = ~r_prev & r_sync;

endmodule

// File: rtl/gc_rx_decoder.sv
// GameCube controller reply receiver: mid-bit samples each 4 us cell after
// the poll generator releases the line, checks the stop bit and publishes
// the frame together with the decoded poll fields.
module gc_rx_decoder
  import gc_pkg::*;
#(
  parameter int SAMPLE_CLKS  = GC_SAMPLE_CLKS,
  parameter int BIT_MAX_CLKS = GC_BIT_MAX_CLKS,
  parameter int TIMEOUT_CLKS = GC_TIMEOUT_CLKS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gc_data_in,
  input  logic        gc_enable,
  input  logic [2:0]  connection_type,
  output logic        ready,
  output logic        rx_valid,
  output logic        rx_error,
  output logic [6:0]  rx_len,
  output logic [79:0] rx_data,
  output logic [15:0] buttons,
  output logic [7:0]  stick_x,
  output logic [7:0]  stick_y,
  output logic [7:0]  cstick_x,
  output logic [7:0]  cstick_y,
  output logic [7:0]  trig_l,
  output logic [7:0]  trig_r
);

  localparam int CELL_W = $clog2(BIT_MAX_CLKS);
  localparam int WAIT_W = $clog2(TIMEOUT_CLKS);

  logic w_line;
  logic w_lineFall;
  logic w_lineRise;

  gc_line_sync u_lineSync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (gc_data_in),
    .o_line  (w_line),
    .o_fall  (w_lineFall),
    .o_rise  (w_lineRise)
  );

  gcRxState_t        r_state;
  logic              r_enPrev;
  logic              r_stopLow;
  logic [6:0]        r_expLen;
  logic [6:0]        r_bitCnt;
  logic [WAIT_W-1:0] r_waitCnt;
  logic [CELL_W-1:0] r_cellCnt;
  logic [79:0]       r_shreg;
  logic [79:0]       r_rxData;
  logic [6:0]        r_rxLen;
  logic [15:0]       r_buttons;
  logic [7:0]        r_stickX;
  logic [7:0]        r_stickY;
  logic [7:0]        r_cstickX;
  logic [7:0]        r_cstickY;
  logic [7:0]        r_trigL;
  logic [7:0]        r_trigR;
  logic              r_ready;
  logic              r_rxValid;
  logic              r_rxError;

  logic w_arm;
  logic w_abort;
  logic w_timeout;
  logic w_cellMax;
  logic w_sampleNow;
  logic w_goodDone;
  logic w_badDone;

  assign w_arm       = gc_enable & ~r_enPrev;
  assign w_abort     = ~gc_enable & (r_state != IDLE);
  assign w_timeout   = (r_waitCnt == WAIT_W'(TIMEOUT_CLKS - 1));
  assign w_cellMax   = (r_cellCnt == CELL_W'(BIT_MAX_CLKS - 1));
  assign w_sampleNow = (r_cellCnt == CELL_W'(SAMPLE_CLKS - 1));

  // Decide whether this cycle finishes the frame well or badly (abort is handled separately)
  always_comb begin
    w_goodDone = 1'b0;
    w_badDone  = 1'b0;
    case (r_state)
      WAIT_EDGE: w_badDone = ~w_lineFall & w_timeout;
      WAIT_HIGH: w_badDone = ~w_line & w_cellMax;
      STOP: begin
        if (r_stopLow) begin
          w_goodDone = w_lineRise;
          w_badDone  = ~w_lineRise & w_cellMax;
        end else begin
          w_badDone  = ~w_lineFall & w_timeout;
        end
      end
      default: begin
        w_goodDone = 1'b0;
        w_badDone  = 1'b0;
      end
    endcase
  end

  // Receiver FSM: abort beats completion, completion beats normal cell sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_enPrev  <= 1'b1;
      r_stopLow <= 1'b0;
      r_expLen  <= '0;
      r_bitCnt  <= '0;
      r_waitCnt <= '0;
      r_cellCnt <= '0;
      r_shreg   <= '0;
      r_rxData  <= '0;
      r_rxLen   <= '0;
      r_buttons <= '0;
      r_stickX  <= '0;
      r_stickY  <= '0;
      r_cstickX <= '0;
      r_cstickY <= '0;
      r_trigL   <= '0;
      r_trigR   <= '0;
      r_ready   <= 1'b0;
      r_rxValid <= 1'b0;
      r_rxError <= 1'b0;
    end else begin
      r_enPrev  <= gc_enable;
      r_ready   <= 1'b0;
      r_rxValid <= 1'b0;
      r_rxError <= 1'b0;
      if (w_abort) begin
        r_state <= IDLE;
      end else if (w_goodDone) begin
        r_rxData  <= r_shreg & gcLenMask(r_expLen);
        r_rxLen   <= r_expLen;
        if (r_expLen == 7'(GC_LEN_POLL)) begin
          r_buttons <= r_shreg[63:48];
          r_stickX  <= r_shreg[47:40];
          r_stickY  <= r_shreg[39:32];
          r_cstickX <= r_shreg[31:24];
          r_cstickY <= r_shreg[23:16];
          r_trigL   <= r_shreg[15:8];
          r_trigR   <= r_shreg[7:0];
        end
        r_ready   <= 1'b1;
        r_rxValid <= 1'b1;
        r_state   <= IDLE;
      end else if (w_badDone) begin
        r_ready   <= 1'b1;
        r_rxError <= 1'b1;
        r_state   <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_arm) begin
              r_expLen  <= gcReplyLen(connection_type);
              r_shreg   <= '0;
              r_bitCnt  <= '0;
              r_waitCnt <= '0;
              r_state   <= WAIT_EDGE;
            end
          end
          WAIT_EDGE: begin
            if (w_lineFall) begin
              r_cellCnt <= '0;
              r_state   <= SAMPLE;
            end else begin
              r_waitCnt <= r_waitCnt + 1'b1;
            end
          end
          SAMPLE: begin
            r_cellCnt <= r_cellCnt + 1'b1;
            if (w_sampleNow) begin
              r_shreg  <= {r_shreg[78:0], w_line};
              r_bitCnt <= r_bitCnt + 1'b1;
              r_state  <= WAIT_HIGH;
            end
          end
          WAIT_HIGH: begin
            if (w_line) begin
              r_waitCnt <= '0;
              r_stopLow <= 1'b0;
              r_state   <= (r_bitCnt == r_expLen) ? STOP : WAIT_EDGE;
            end else begin
              r_cellCnt <= r_cellCnt + 1'b1;
            end
          end
          STOP: begin
            if (!r_stopLow) begin
              if (w_lineFall) begin
                r_stopLow <= 1'b1;
                r_cellCnt <= '0;
              end else begin
                r_waitCnt <= r_waitCnt + 1'b1;
              end
            end else begin
              r_cellCnt <= r_cellCnt + 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign ready    = r_ready;
  assign rx_valid = r_rxValid;
  assign rx_error = r_rxError;
  assign rx_len   = r_rxLen;
  assign rx_data  = r_rxData;
  assign buttons  = r_buttons;
  assign stick_x  = r_stickX;
  assign stick_y  = r_stickY;
  assign cstick_x = r_cstickX;
  assign cstick_y = r_cstickY;
  assign trig_l   = r_trigL;
  assign trig_r   = r_trigR;

endmodule

// File: tb/tb_gc_rx_decoder.sv
// Bench for gc_rx_decoder: a line model plays controller replies with
// randomised pulse widths, expected results go into a scoreboard queue and
// a monitor compares them whenever the decoder pulses ready.
`timescale 1ns/1ps
module tb_gc_rx_decoder;

  localparam int CELL_CLKS = 240;

  logic        clk;
  logic        rst_n;
  logic        gcDataIn;
  logic        gcEnable;
  logic [2:0]  connType;
  logic        ready;
  logic        rxValid;
  logic        rxError;
  logic [6:0]  rxLen;
  logic [79:0] rxData;
  logic [15:0] buttons;
  logic [7:0]  stickX, stickY, cstickX, cstickY, trigL, trigR;

  gc_rx_decoder dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .gc_data_in      (gcDataIn),
    .gc_enable       (gcEnable),
    .connection_type (connType),
    .ready           (ready),
    .rx_valid        (rxValid),
    .rx_error        (rxError),
    .rx_len          (rxLen),
    .rx_data         (rxData),
    .buttons         (buttons),
    .stick_x         (stickX),
    .stick_y         (stickY),
    .cstick_x        (cstickX),
    .cstick_y        (cstickY),
    .trig_l          (trigL),
    .trig_r          (trigR)
  );

  typedef struct {
    bit          isValid;
    logic [6:0]  len;
    logic [79:0] data;
    logic [15:0] buttons;
    logic [47:0] sticks;
  } expect_t;

  expect_t     sbQueue[$];
  expect_t     monEntry;
  int          checks = 0;
  int          errors = 0;

  logic [6:0]  mLen;
  logic [79:0] mData;
  logic [15:0] mButtons;
  logic [47:0] mSticks;

  // Free-running clock, roughly 60 MHz
  initial clk = 1'b0;
  always #8 clk = ~clk;

  // Hard stop in case something wedges the stimulus
  initial begin
    #(130000 * 16);
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string name, input logic [79:0] actual, input logic [79:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Compare every published output against the model's view
  task automatic checkOutput(input string tag);
    checkVal({tag, " rx_len"}, 80'(rxLen), 80'(mLen));
    checkVal({tag, " rx_data"}, rxData, mData);
    checkVal({tag, " buttons"}, 80'(buttons), 80'(mButtons));
    checkVal({tag, " sticks"}, 80'({stickX, stickY, cstickX, cstickY, trigL, trigR}), 80'(mSticks));
  endtask

  function automatic int replyLen(input logic [2:0] ct);
    if (ct == 3'd0) return 24;
    if (ct == 3'd1) return 80;
    return 64;
  endfunction

  // Reference model: a good reply makes the received bits the new frame
  task automatic expectFrame(input logic [2:0] ct, input logic [79:0] value);
    int n;
    logic [79:0] acc;
    expect_t e;
    n = replyLen(ct);
    acc = '0;
    for (int i = n - 1; i >= 0; i--) acc = acc * 2 + 80'(value[i]);
    mData = acc;
    mLen  = 7'(n);
    if (n == 64) begin
      mButtons = acc[63:48];
      mSticks  = acc[47:0];
    end
    e.isValid = 1'b1; e.len = mLen; e.data = mData; e.buttons = mButtons; e.sticks = mSticks;
    sbQueue.push_back(e);
  endtask

  // Reference model: an error leaves every published field untouched
  task automatic expectError();
    expect_t e;
    e.isValid = 1'b0; e.len = mLen; e.data = mData; e.buttons = mButtons; e.sticks = mSticks;
    sbQueue.push_back(e);
  endtask

  // Monitor: every ready pulse must match the oldest expectation
  always @(negedge clk) begin
    if (ready) begin
      if (sbQueue.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected ready: got valid=%0b error=%0b, expected no pulse", rxValid, rxError);
      end else begin
        monEntry = sbQueue.pop_front();
        checkVal("rx_valid", 80'(rxValid), 80'(monEntry.isValid));
        checkVal("rx_error", 80'(rxError), 80'(!monEntry.isValid));
        checkVal("rx_len", 80'(rxLen), 80'(monEntry.len));
        checkVal("rx_data", rxData, monEntry.data);
        checkVal("buttons", 80'(buttons), 80'(monEntry.buttons));
        checkVal("sticks", 80'({stickX, stickY, cstickX, cstickY, trigL, trigR}), 80'(monEntry.sticks));
      end
    end else if (rxValid || rxError) begin
      checks++;
      errors++;
      $display("[TB] FAIL stray pulse: got valid=%0b error=%0b without ready, expected none", rxValid, rxError);
    end
  end

  task automatic idleClocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 4 us cell: 1 = short low, 0 = long low, with jitter
  task automatic sendCell(input bit b);
    int low;
    low = b ? int'($urandom_range(75, 45)) : int'($urandom_range(190, 150));
    gcDataIn = 1'b0;
    idleClocks(low);
    gcDataIn = 1'b1;
    idleClocks(CELL_CLKS - low);
  endtask

  task automatic sendStop();
    gcDataIn = 1'b0;
    idleClocks(int'($urandom_range(70, 50)));
    gcDataIn = 1'b1;
    idleClocks(120);
  endtask

  // Send the first 'count' bits of an n-bit reply, MSB first
  task automatic sendBits(input logic [79:0] value, input int n, input int count);
    for (int k = 0; k < count; k++) sendCell(value[n - 1 - k]);
  endtask

  task automatic arm(input logic [2:0] ct);
    gcEnable = 1'b0;
    connType = ct;
    idleClocks(4);
    gcEnable = 1'b1;
  endtask

  task automatic waitDrain(input int budget);
    int k;
    k = 0;
    while (sbQueue.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (sbQueue.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending responses after %0d clocks, expected 0", sbQueue.size(), budget);
      sbQueue.delete();
    end
  endtask

  // A complete good reply; connection_type is switched to ctAfter once armed
  task automatic applyStimulus(input logic [2:0] ct, input logic [79:0] value, input logic [2:0] ctAfter);
    int n;
    n = replyLen(ct);
    expectFrame(ct, value);
    arm(ct);
    idleClocks(int'($urandom_range(200, 30)));
    connType = ctAfter;
    sendBits(value, n, n);
    sendStop();
    waitDrain(500);
  endtask

  function automatic logic [79:0] randValue();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  // Main stimulus sequence
  initial begin
    int cnt;
    rst_n    = 1'b0;
    gcDataIn = 1'b1;
    gcEnable = 1'b0;
    connType = 3'd0;
    mLen = '0; mData = '0; mButtons = '0; mSticks = '0;
    idleClocks(3);
    checkVal("reset ready", 80'(ready), 80'(0));
    checkVal("reset rx_valid", 80'(rxValid), 80'(0));
    checkVal("reset rx_error", 80'(rxError), 80'(0));
    checkOutput("reset");
    rst_n = 1'b1;
    idleClocks(5);

    $display("[TB] poll frame");
    applyStimulus(3'd2, 80'h0080_8080_8080_2020, 3'd2);
    checkVal("poll rx_len", 80'(rxLen), 80'(64));
    checkVal("poll buttons", 80'(buttons), 80'h0080);
    checkVal("poll stick_x", 80'(stickX), 80'h80);
    checkVal("poll trig_r", 80'(trigR), 80'h20);

    $display("[TB] probe reply");
    applyStimulus(3'd0, 80'h090000, 3'd0);
    checkVal("probe rx_len", 80'(rxLen), 80'(24));
    checkVal("probe rx_data", rxData, 80'h090000);
    checkVal("probe buttons held", 80'(buttons), 80'h0080);
    checkVal("probe stick_x held", 80'(stickX), 80'h80);

    $display("[TB] timeout");
    expectError();
    arm(3'd2);
    cnt = 0;
    while (!ready && cnt < 7000) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (cnt < 5997 || cnt > 6003) begin
      errors++;
      $display("[TB] FAIL timeout latency: got %0d clocks, expected 6000 +/- 3", cnt);
    end
    idleClocks(2);
    checkVal("timeout rx_data held", rxData, 80'h090000);
    waitDrain(10);

    $display("[TB] stuck low in bit 5");
    expectError();
    arm(3'd2);
    idleClocks(50);
    sendBits(randValue(), 64, 4);
    gcDataIn = 1'b0;
    cnt = 0;
    while (!ready && cnt < 700) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (cnt < 478 || cnt > 486) begin
      errors++;
      $display("[TB] FAIL stuck latency: got %0d clocks, expected 480 + sync delay", cnt);
    end
    idleClocks(600 - cnt);
    gcDataIn = 1'b1;
    waitDrain(10);
    idleClocks(20);

    $display("[TB] abort after 30 bits");
    arm(3'd2);
    idleClocks(60);
    sendBits(randValue(), 64, 30);
    gcEnable = 1'b0;
    idleClocks(40);
    checkOutput("abort hold");
    applyStimulus(3'd1, randValue(), 3'd0);

    $display("[TB] reset during bit 40");
    arm(3'd2);
    idleClocks(40);
    sendBits(randValue(), 64, 39);
    gcDataIn = 1'b0;
    idleClocks(30);
    rst_n = 1'b0;
    #1;
    mLen = '0; mData = '0; mButtons = '0; mSticks = '0;
    checkVal("mid reset ready", 80'(ready), 80'(0));
    checkOutput("mid reset");
    idleClocks(2);
    rst_n = 1'b1;
    gcDataIn = 1'b1;
    idleClocks(6500);
    checkOutput("after reset");
    applyStimulus(3'd5, randValue(), 3'd0);

    waitDrain(100);
    checkVal("scoreboard empty", 80'(sbQueue.size()), 80'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
